// File: rtl/miniRISC_pkg.sv
// Shared miniRISC definitions for the register file: the bulk-clear
// sequencer states and the default data width and depth.
package miniRISC_pkg;

  localparam int DEFAULT_DW    = 32;
  localparam int DEFAULT_DEPTH = 32;

  // Bulk-clear sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

endpackage

// File: rtl/reg_file_clr_seq.sv
// Bulk-clear sequencer. It zeroes one register per cycle, in order from
// entry 0 up to DEPTH-1, then gives a one-cycle done pulse. While it runs,
// normal writes are refused.
module reg_file_clr_seq
  import miniRISC_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  input  logic          wr_en,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          wr_stall,
  output logic          clrWrEn,
  output logic [AW-1:0] clrAddr
);

  // The index is one bit wider than the address, so it never wraps.
  // The terminal compare is made explicitly against DEPTH-1.
  localparam logic [AW:0] LAST_IDX  = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] IDX_ONE   = (AW+1)'(1);
  localparam logic [AW:0] IDX_ZERO  = {(AW+1){1'b0}};

  clr_state_t  state;
  clr_state_t  stateNext;
  logic [AW:0] clrIdx;
  logic [AW:0] clrIdxNext;

  // State and index registers; an async reset returns the sequencer to IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      clrIdx <= IDX_ZERO;
    end else begin
      state  <= stateNext;
      clrIdx <= clrIdxNext;
    end
  end

  // Next state, index advance and status flags for the clear sequence
  always_comb begin
    stateNext  = state;
    clrIdxNext = clrIdx;
    clr_busy   = 1'b0;
    clr_done   = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req) begin
          stateNext  = CLEAR;
          clrIdxNext = IDX_ZERO;
        end else begin
          stateNext  = IDLE;
        end
      end
      CLEAR: begin
        // clr_req is not examined here, so a new request cannot restart a clear
        clr_busy   = 1'b1;
        clrIdxNext = clrIdx + IDX_ONE;
        if (clrIdx == LAST_IDX) begin
          stateNext = DONE;
        end else begin
          stateNext = CLEAR;
        end
      end
      DONE: begin
        // clr_req is not examined here; a request still held is taken from IDLE
        clr_done  = 1'b1;
        stateNext = IDLE;
      end
      default: begin
        stateNext  = IDLE;
        clrIdxNext = IDX_ZERO;
      end
    endcase
  end

  assign wr_stall = clr_busy & wr_en;
  assign clrWrEn  = clr_busy;
  assign clrAddr  = clrIdx[AW-1:0];

endmodule

// File: rtl/reg_file_mp.sv
// Register file for the miniRISC datapath with several read ports.
// Width, depth and read-port count are set by parameters. Register 0 can be
// made to always read zero. Write data can be forwarded to a read port in
// the same cycle. A bulk-clear engine is included, and a separate debug
// port reads the stored value directly.
module reg_file_mp
  import miniRISC_pkg::*;
#(
  parameter int DW      = DEFAULT_DW,
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int AW      = $clog2(DEPTH),
  parameter int NRD     = 2,
  parameter int ZERO_R0 = 0,
  parameter int BYPASS  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DW-1:0]     wr_data,
  output logic              wr_stall,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DW-1:0]     dbg_data
);

  localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
  localparam logic [DW-1:0] DATA_ZERO = {DW{1'b0}};
  localparam logic          HARD_ZERO = (ZERO_R0 != 0);
  localparam logic          FWD_EN    = (BYPASS != 0);

  logic [DW-1:0] storage [DEPTH];
  logic          clrWrEn;
  logic [AW-1:0] clrAddr;
  logic          wrDrop;
  logic          wrFire;

  reg_file_clr_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) uClrSeq (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .wr_en    (wr_en),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .wr_stall (wr_stall),
    .clrWrEn  (clrWrEn),
    .clrAddr  (clrAddr)
  );

  // If register 0 is hard-wired to zero, writes to it are discarded.
  assign wrDrop = HARD_ZERO && (wr_addr == ADDR_ZERO);
  assign wrFire = wr_en && !wr_stall && !wrDrop;

  // Storage update: async reset zeroes every entry, the clear engine is served first, then normal writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        storage[i] <= DATA_ZERO;
      end
    end else if (clrWrEn) begin
      storage[clrAddr] <= DATA_ZERO;
    end else if (wrFire) begin
      storage[wr_addr] <= wr_data;
    end
  end

  // Read ports: each is a combinational mux that gives hard zero first, then forwarded write data, then storage
  for (genvar gi = 0; gi < NRD; gi++) begin : gRdPort
    logic [AW-1:0] portAddr;
    logic          portZero;
    logic          portHit;

    assign portAddr = rd_addr[gi*AW +: AW];
    assign portZero = HARD_ZERO && (portAddr == ADDR_ZERO);
    // A write refused by the clear engine has wrFire low, so it is not forwarded
    assign portHit  = FWD_EN && wrFire && (wr_addr == portAddr);
    assign rd_data[gi*DW +: DW] = portZero ? DATA_ZERO :
                                  (portHit ? wr_data : storage[portAddr]);
  end

  // The debug port always shows the stored value and never forwarded write data
  assign dbg_data = (HARD_ZERO && (dbg_addr == ADDR_ZERO)) ? DATA_ZERO : storage[dbg_addr];

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp. It uses three instances: the default
// configuration, a configuration with register 0 hard-wired to zero, and a
// configuration with 16-bit data, 8 entries and 4 read ports.
module tb_reg_file_mp;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance 0: DW=32 DEPTH=32 NRD=2 ZERO_R0=0 BYPASS=1
  logic [9:0]  d0RdAddr;
  logic [63:0] d0RdData;
  logic        d0WrEn;
  logic [4:0]  d0WrAddr;
  logic [31:0] d0WrData;
  logic        d0WrStall;
  logic        d0ClrReq;
  logic        d0ClrBusy;
  logic        d0ClrDone;
  logic [4:0]  d0DbgAddr;
  logic [31:0] d0DbgData;

  // Instance 1: same as instance 0 but with ZERO_R0=1
  logic [9:0]  d1RdAddr;
  logic [63:0] d1RdData;
  logic        d1WrEn;
  logic [4:0]  d1WrAddr;
  logic [31:0] d1WrData;
  logic        d1WrStall;
  logic        d1ClrReq;
  logic        d1ClrBusy;
  logic        d1ClrDone;
  logic [4:0]  d1DbgAddr;
  logic [31:0] d1DbgData;

  // Instance 2: DW=16 DEPTH=8 NRD=4
  logic [11:0] d2RdAddr;
  logic [63:0] d2RdData;
  logic        d2WrEn;
  logic [2:0]  d2WrAddr;
  logic [15:0] d2WrData;
  logic        d2WrStall;
  logic        d2ClrReq;
  logic        d2ClrBusy;
  logic        d2ClrDone;
  logic [2:0]  d2DbgAddr;
  logic [15:0] d2DbgData;

  reg_file_mp #(.DW(32), .DEPTH(32), .AW(5), .NRD(2), .ZERO_R0(0), .BYPASS(1)) dut0 (
    .clk(clk), .rst(rst), .rd_addr(d0RdAddr), .rd_data(d0RdData),
    .wr_en(d0WrEn), .wr_addr(d0WrAddr), .wr_data(d0WrData), .wr_stall(d0WrStall),
    .clr_req(d0ClrReq), .clr_busy(d0ClrBusy), .clr_done(d0ClrDone),
    .dbg_addr(d0DbgAddr), .dbg_data(d0DbgData)
  );

  reg_file_mp #(.DW(32), .DEPTH(32), .AW(5), .NRD(2), .ZERO_R0(1), .BYPASS(1)) dut1 (
    .clk(clk), .rst(rst), .rd_addr(d1RdAddr), .rd_data(d1RdData),
    .wr_en(d1WrEn), .wr_addr(d1WrAddr), .wr_data(d1WrData), .wr_stall(d1WrStall),
    .clr_req(d1ClrReq), .clr_busy(d1ClrBusy), .clr_done(d1ClrDone),
    .dbg_addr(d1DbgAddr), .dbg_data(d1DbgData)
  );

  reg_file_mp #(.DW(16), .DEPTH(8), .AW(3), .NRD(4), .ZERO_R0(0), .BYPASS(1)) dut2 (
    .clk(clk), .rst(rst), .rd_addr(d2RdAddr), .rd_data(d2RdData),
    .wr_en(d2WrEn), .wr_addr(d2WrAddr), .wr_data(d2WrData), .wr_stall(d2WrStall),
    .clr_req(d2ClrReq), .clr_busy(d2ClrBusy), .clr_done(d2ClrDone),
    .dbg_addr(d2DbgAddr), .dbg_data(d2DbgData)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic sawDone;
    logic sawBusy;

    d0RdAddr = 10'd0; d0WrEn = 1'b0; d0WrAddr = 5'd0; d0WrData = 32'd0; d0ClrReq = 1'b0; d0DbgAddr = 5'd0;
    d1RdAddr = 10'd0; d1WrEn = 1'b0; d1WrAddr = 5'd0; d1WrData = 32'd0; d1ClrReq = 1'b0; d1DbgAddr = 5'd0;
    d2RdAddr = 12'd0; d2WrEn = 1'b0; d2WrAddr = 3'd0; d2WrData = 16'd0; d2ClrReq = 1'b0; d2DbgAddr = 3'd0;

    // 1: reset without a clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_rd0", d0RdData, 64'd0);
    chk("rst_dbg0", d0DbgData, 64'd0);
    chk("rst_rd2", d2RdData, 64'd0);
    chk("rst_busy", d0ClrBusy, 64'd0);
    chk("rst_done", d0ClrDone, 64'd0);
    chk("rst_stall", d0WrStall, 64'd0);
    #1 rst = 1'b0;
    step();

    // 2: write with same-cycle forwarding, then a registered read
    d0WrEn = 1'b1; d0WrAddr = 5'd7; d0WrData = 32'hDEADBEEF;
    d0RdAddr = {5'd8, 5'd7}; d0DbgAddr = 5'd7;
    #1;
    chk("byp_p0", d0RdData[31:0], 64'hDEADBEEF);
    chk("byp_p1_other", d0RdData[63:32], 64'd0);
    chk("byp_dbg_not_fwd", d0DbgData, 64'd0);
    step();
    d0WrEn = 1'b0; d0RdAddr = {5'd7, 5'd0};
    #1;
    chk("wr_p1", d0RdData[63:32], 64'hDEADBEEF);
    chk("wr_dbg", d0DbgData, 64'hDEADBEEF);
    chk("wr_p0_r0", d0RdData[31:0], 64'd0);

    // 3: register 0 hard-wired to zero versus a normal register 0
    d1WrEn = 1'b1; d1WrAddr = 5'd0; d1WrData = 32'h12345678; d1RdAddr = {5'd0, 5'd0}; d1DbgAddr = 5'd0;
    d0WrEn = 1'b1; d0WrAddr = 5'd0; d0WrData = 32'h12345678; d0RdAddr = {5'd0, 5'd0}; d0DbgAddr = 5'd0;
    #1;
    chk("z1_byp_p0", d1RdData[31:0], 64'd0);
    chk("z0_byp_p0", d0RdData[31:0], 64'h12345678);
    step();
    d1WrEn = 1'b0; d0WrEn = 1'b0;
    #1;
    chk("z1_p0", d1RdData[31:0], 64'd0);
    chk("z1_p1", d1RdData[63:32], 64'd0);
    chk("z1_dbg", d1DbgData, 64'd0);
    chk("z0_p1", d0RdData[63:32], 64'h12345678);
    chk("z0_dbg", d0DbgData, 64'h12345678);
    d1WrEn = 1'b1; d1WrAddr = 5'd3; d1WrData = 32'h0000A5A5;
    step();
    d1WrEn = 1'b0; d1RdAddr = {5'd3, 5'd0};
    #1;
    chk("z1_nonzero", d1RdData[63:32], 64'h0000A5A5);

    // 4: fill every entry with addr+1, then run a bulk clear
    for (int i = 0; i < 32; i++) begin
      d0WrEn = 1'b1; d0WrAddr = 5'(i); d0WrData = 32'(i + 1);
      step();
    end
    d0WrEn = 1'b0;
    d0RdAddr = {5'd31, 5'd0};
    #1;
    chk("fill_p0", d0RdData[31:0], 64'd1);
    chk("fill_p1", d0RdData[63:32], 64'd32);
    d0ClrReq = 1'b1;
    step();
    d0ClrReq = 1'b0;
    for (int k = 0; k < 32; k++) begin
      d0ClrReq = (k == 20);
      if (k == 16) begin
        d0WrEn = 1'b1; d0WrAddr = 5'd5; d0WrData = 32'h0000FFFF;
        d0RdAddr = {5'd20, 5'd5};
      end else begin
        d0WrEn = 1'b0;
      end
      #1;
      chk("clr_busy", d0ClrBusy, 64'd1);
      chk("clr_no_done", d0ClrDone, 64'd0);
      chk("clr_stall", d0WrStall, 64'(k == 16));
      if (k == 16) begin
        chk("clr_p0_cleared", d0RdData[31:0], 64'd0);
        chk("clr_p1_pending", d0RdData[63:32], 64'd21);
      end
      step();
    end
    d0ClrReq = 1'b0; d0WrEn = 1'b0;
    #1;
    chk("clr_done_pulse", d0ClrDone, 64'd1);
    chk("clr_busy_low", d0ClrBusy, 64'd0);
    step();
    chk("clr_done_once", d0ClrDone, 64'd0);
    chk("clr_idle", d0ClrBusy, 64'd0);
    for (int a = 0; a < 32; a++) begin
      d0DbgAddr = 5'(a);
      #1;
      chk("clr_entry_zero", d0DbgData, 64'd0);
    end

    // 5: reset in the middle of a clear
    d0WrEn = 1'b1; d0WrAddr = 5'd30; d0WrData = 32'h00000044;
    step();
    d0WrEn = 1'b0; d0DbgAddr = 5'd30; d0RdAddr = {5'd30, 5'd30};
    d0ClrReq = 1'b1;
    step();
    d0ClrReq = 1'b0;
    repeat (10) step();
    chk("mid_busy", d0ClrBusy, 64'd1);
    chk("mid_pending", d0DbgData, 64'h00000044);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", d0ClrBusy, 64'd0);
    chk("mid_rst_dbg", d0DbgData, 64'd0);
    chk("mid_rst_p1", d0RdData[63:32], 64'd0);
    rst = 1'b0;
    sawDone = 1'b0;
    sawBusy = 1'b0;
    for (int c = 0; c < 40; c++) begin
      sawDone = sawDone | d0ClrDone;
      sawBusy = sawBusy | d0ClrBusy;
      step();
    end
    chk("mid_no_done", sawDone, 64'd0);
    chk("mid_stays_idle", sawBusy, 64'd0);

    // 6: narrow and shallow configuration with 4 ports, and a clear while clr_req is held
    for (int i = 1; i <= 4; i++) begin
      d2WrEn = 1'b1; d2WrAddr = 3'(i); d2WrData = 16'(i * 257);
      step();
    end
    d2WrEn = 1'b0;
    d2RdAddr = {3'd4, 3'd3, 3'd2, 3'd1};
    #1;
    chk("np_p0", d2RdData[15:0], 64'h0101);
    chk("np_p1", d2RdData[31:16], 64'h0202);
    chk("np_p2", d2RdData[47:32], 64'h0303);
    chk("np_p3", d2RdData[63:48], 64'h0404);
    d2ClrReq = 1'b1;
    step();
    for (int k = 0; k < 8; k++) begin
      chk("np_busy", d2ClrBusy, 64'd1);
      step();
    end
    chk("np_done", d2ClrDone, 64'd1);
    chk("np_done_busy", d2ClrBusy, 64'd0);
    chk("np_cleared", d2RdData, 64'd0);
    step();
    chk("np_idle_busy", d2ClrBusy, 64'd0);
    chk("np_idle_done", d2ClrDone, 64'd0);
    step();
    chk("np_restart", d2ClrBusy, 64'd1);
    d2ClrReq = 1'b0;
    repeat (8) step();
    chk("np_restart_done", d2ClrDone, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
